car_spawner: RTL and testbench
==============================

// Module: car_spawner
// PURPOSE
//  Producer side of a crossy-road lane: drives the NL input of the lane's leftmost cell.
//  Generates a lane step tick and, on selected ticks, a one-cycle spawn pulse.
//  Spawn is chosen from a 10-bit LFSR roll, gated by a density level.
//  Spawns keep a minimum gap between cars; a spawn is forced after a long empty stretch.
//  One instance per lane; lane cells advance on step and sample spawn as NL.
// PARAMETERS
//  SEED      10'h001  LFSR seed; 0 is replaced by 10'h001
//  STEP_DIV  25000000 clk cycles per step; minimum 2
//  MIN_GAP   2        steps after a spawn with no spawn allowed (= dark LEDs between cars)
//  MAX_EMPTY 6        ARMED steps without spawn before a forced spawn; 0 disables forcing
// PORTS
//  clk        in   1  clock
//  reset      in   1  synchronous, active-high
//  enable     in   1  lane running; low freezes the lane
//  density    in   4  spawn when roll < density; 0 = random spawns off
//  step       out  1  one-cycle lane advance tick
//  spawn      out  1  NL for first cell; high only in a cycle where step=1
//  car_count  out  8  spawns issued, saturates at 255
// BEHAVIOUR
//  Reset (overrides all inputs):
//   - lfsr=SEED, or 10'h001 if SEED is 0; divider=0; step=0; spawn=0; car_count=0
//   - state=IDLE; gap_cnt=0; empty_cnt=0
//  Divider:
//   - enable=1: counts 0..STEP_DIV-1 and wraps.
//   - step is registered; it is high for one cycle in the cycle after count==STEP_DIV-1.
//   - Step n is therefore high in the (n*STEP_DIV)-th cycle after enable is first sampled 1.
//   - enable=0: divider cleared to 0, step=0 next cycle.
//  LFSR:
//   - Fibonacci x^10+x^7+1 (maximal length); shifts once per step.
//   - roll = lfsr[3:0] before the shift. The all-zero state is unreachable.
//  All decisions are made in the cycle with count==STEP_DIV-1.
//   - spawn is registered so it is high in the same cycle as step. Latency 1 clk.
//  FSM (state advances only on steps, except the enable rules below):
//   - IDLE:
//     - enable=1 -> GAP, gap_cnt=MIN_GAP (or -> ARMED if MIN_GAP=0).
//   - GAP: no spawn.
//     - Each step decrements gap_cnt.
//     - On the step where gap_cnt==1 -> ARMED, empty_cnt=0. That step is not eligible.
//   - ARMED, on each step:
//     - Spawn if roll < density, or if MAX_EMPTY!=0 and empty_cnt==MAX_EMPTY-1 (forced).
//     - On spawn: empty_cnt=0; -> GAP with gap_cnt=MIN_GAP (stay ARMED if MIN_GAP=0).
//     - Otherwise empty_cnt++.
//   - Any state, enable=0:
//     - -> IDLE next cycle; spawn=0, step=0.
//     - gap_cnt/empty_cnt cleared; lfsr and car_count kept.
//     - On re-enable the gap is re-enforced through IDLE->GAP.
//  Boundary rules:
//   - Minimum spawn spacing is MIN_GAP+1 steps.
//   - Forced-only period (density=0) is MIN_GAP+MAX_EMPTY steps.
//   - car_count holds at 255.
//   - density=15 never spawns on roll 15 unless the spawn is forced.
//   - enable falling in the decision cycle: that step and spawn are suppressed.
// STRUCTURE
//  crossy_pkg:
//   - typedef enum {IDLE, GAP, ARMED} spawn_state_t
//   - localparam LFSR_W=10 and LFSR_TAPS=10'h240
//  Sub-module lfsr_step:
//   - Inputs clk, reset, adv; parameter SEED; output q[9:0].
//   - Instantiated once; adv=decision cycle.
// TESTING (STEP_DIV=4, MIN_GAP=2, MAX_EMPTY=3, SEED=10'h001 unless stated)
//  1. Reset mid-run with enable=1:
//     - next cycle step=0, spawn=0, car_count=0, lfsr=10'h001.
//  2. density=0, enable=1 from reset:
//     - step every 4 clk.
//     - spawn only on steps 5,10,15,... (forced, period 5).
//     - car_count 1,2,3 after steps 5,10,15.
//  3. density=15, run 200 steps:
//     - every spawn coincides with step; no two spawns fewer than 3 steps apart.
//     - Every spawn on roll!=15, and every forced spawn, matches a reference LFSR model.
//  4. Drop enable for 10 cycles right after a spawn, then re-enable:
//     - step/spawn stay 0 while low.
//     - First possible spawn is step 3 after re-enable; car_count is unchanged.
//  5. SEED=0, MAX_EMPTY=0, density=0, 1000 steps:
//     - spawn never asserts; lfsr never 0; car_count=0.
//  6. Force car_count to 254 and run density=0:
//     - car_count reaches 255 and holds across further spawns.

Source files
------------

// File: rtl/car_spawner_pkg.sv
// Shared types and constants for the crossy-road lane spawner.
package crossy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        ARMED = 2'd2
    } spawn_state_t;

    localparam int unsigned LFSR_W = 10;
    // Taps for x^10 + x^7 + 1: bits 9 and 6 feed the shift-in bit.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'h240;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? 10'h001 : s;
    endfunction

endpackage

// File: rtl/car_spawner_if.sv
// Lane control/status bundle between a lane controller and its spawner.
interface car_spawner_if;
    logic       enable;
    logic [3:0] density;
    logic       step;
    logic       spawn;
    logic [7:0] car_count;

    modport master (
        output enable, density,
        input  step, spawn, car_count
    );

    modport slave (
        input  enable, density,
        output step, spawn, car_count
    );
endinterface

// File: rtl/car_spawner_lfsr.sv
// 10-bit Fibonacci LFSR that advances one position when adv is high.
module lfsr_step
    import crossy_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 10'h001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(SEED);

    logic [LFSR_W-1:0] q_q;

    // Shift left, feeding in the XOR of the tapped bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= SEED_EFF;
        end else if (adv) begin
            q_q <= {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/car_spawner.sv
// Lane producer: step divider, gap/armed spawn FSM and spawn counter.
module car_spawner
    import crossy_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED      = 10'h001,
    parameter int unsigned       STEP_DIV  = 25000000,
    parameter int unsigned       MIN_GAP   = 2,
    parameter int unsigned       MAX_EMPTY = 6
) (
    input  logic           clk,
    input  logic           reset,
    car_spawner_if.slave   lane
);

    localparam int CNT_W   = $clog2(STEP_DIV);
    localparam int GAP_W   = $clog2(MIN_GAP + 2);
    localparam int EMPTY_W = $clog2(MAX_EMPTY + 2);

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               step_q,  step_d;
    logic               spawn_q, spawn_d;
    logic [7:0]         cc_q,    cc_d;
    spawn_state_t       state_q, state_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;

    logic [LFSR_W-1:0]  lfsr;
    logic               dec;
    logic               forced;
    logic               hit;

    assign dec    = lane.enable && (cnt_q == CNT_W'(STEP_DIV - 1));
    assign forced = (MAX_EMPTY != 0) && (empty_q == EMPTY_W'(MAX_EMPTY - 1));
    // roll is sampled before this decision's shift takes effect.
    assign hit    = (lfsr[3:0] < lane.density) || forced;

    lfsr_step #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (dec),
        .q     (lfsr)
    );

    // Next-state for divider, FSM, gap/empty counters and outputs.
    always_comb begin
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        spawn_d = 1'b0;
        cc_d    = cc_q;
        state_d = state_q;
        gap_d   = gap_q;
        empty_d = empty_q;
        if (!lane.enable) begin
            cnt_d   = '0;
            state_d = IDLE;
            gap_d   = '0;
            empty_d = '0;
        end else begin
            cnt_d  = dec ? '0 : cnt_q + 1'b1;
            step_d = dec;
            unique case (state_q)
                IDLE: begin
                    if (MIN_GAP == 0) begin
                        state_d = ARMED;
                        empty_d = '0;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(MIN_GAP);
                    end
                end
                GAP: begin
                    if (dec) begin
                        if (gap_q <= GAP_W'(1)) begin
                            state_d = ARMED;
                            gap_d   = '0;
                            empty_d = '0;
                        end else begin
                            gap_d = gap_q - 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (dec) begin
                        if (hit) begin
                            spawn_d = 1'b1;
                            cc_d    = (cc_q == 8'hFF) ? cc_q : cc_q + 8'd1;
                            empty_d = '0;
                            if (MIN_GAP != 0) begin
                                state_d = GAP;
                                gap_d   = GAP_W'(MIN_GAP);
                            end
                        end else begin
                            empty_d = empty_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            step_q  <= 1'b0;
            spawn_q <= 1'b0;
            cc_q    <= '0;
            state_q <= IDLE;
            gap_q   <= '0;
            empty_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            spawn_q <= spawn_d;
            cc_q    <= cc_d;
            state_q <= state_d;
            gap_q   <= gap_d;
            empty_q <= empty_d;
        end
    end

    assign lane.step      = step_q;
    assign lane.spawn     = spawn_q;
    assign lane.car_count = cc_q;

endmodule

// File: tb/tb_car_spawner.sv
// Self-checking bench for car_spawner: cycle model + scoreboard, phase table, corner sequences.
module tb_car_spawner;

    localparam int SD = 4;
    localparam int MG = 2;
    localparam int ME = 3;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    car_spawner_if bus_a ();
    car_spawner_if bus_b ();

    car_spawner #(
        .SEED      (10'h001),
        .STEP_DIV  (SD),
        .MIN_GAP   (MG),
        .MAX_EMPTY (ME)
    ) u_a (
        .clk   (clk),
        .reset (rst_a),
        .lane  (bus_a.slave)
    );

    car_spawner #(
        .SEED      (10'h000),
        .STEP_DIV  (SD),
        .MIN_GAP   (MG),
        .MAX_EMPTY (0)
    ) u_b (
        .clk   (clk),
        .reset (rst_b),
        .lane  (bus_b.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of instance A
    typedef struct {
        logic       step;
        logic       spawn;
        logic [7:0] cc;
        logic [9:0] lfsr;
    } exp_t;
    exp_t sbq[$];

    int         m_cyc, m_wait, m_empty, m_cc;
    bit         m_idle, m_step, m_spawn;
    logic [9:0] m_lfsr;

    task automatic model_a(input bit r, input bit en, input logic [3:0] den);
        bit         d;
        logic [3:0] roll;
        exp_t       e;
        if (r) begin
            m_cyc = 0; m_idle = 1; m_wait = 0; m_empty = 0;
            m_lfsr = 10'h001; m_cc = 0; m_step = 0; m_spawn = 0;
        end else if (!en) begin
            m_cyc = 0; m_idle = 1; m_wait = 0; m_empty = 0;
            m_step = 0; m_spawn = 0;
        end else begin
            if (m_idle) begin
                m_idle = 0;
                m_wait = MG;
            end
            d = ((m_cyc % SD) == SD - 1);
            m_cyc++;
            m_step  = d;
            m_spawn = 0;
            if (d) begin
                roll   = m_lfsr[3:0];
                m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
                if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) m_empty = 0;
                end else if (roll < den || m_empty == ME - 1) begin
                    m_spawn = 1;
                    m_empty = 0;
                    m_wait  = MG;
                    if (m_cc < 255) m_cc++;
                end else begin
                    m_empty++;
                end
            end
        end
        e.step = m_step; e.spawn = m_spawn; e.cc = 8'(m_cc); e.lfsr = m_lfsr;
        sbq.push_back(e);
    endtask

    // One clock of instance A: drive, model, sample after the edge, compare.
    task automatic tick_a(input bit r, input bit en, input logic [3:0] den,
                          output bit st, output bit sp);
        exp_t e;
        rst_a = r;
        bus_a.enable  = en;
        bus_a.density = den;
        @(posedge clk);
        model_a(r, en, den);
        #1;
        e = sbq.pop_front();
        st = bus_a.step;
        sp = bus_a.spawn;
        check("step",      int'(bus_a.step),      int'(e.step));
        check("spawn",     int'(bus_a.spawn),     int'(e.spawn));
        check("car_count", int'(bus_a.car_count), int'(e.cc));
        check("lfsr",      int'(u_a.u_lfsr.q),    int'(e.lfsr));
        if (bus_a.spawn) check("spawn_with_step", int'(bus_a.step), 1);
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [3:0] den;
        int         cycles;
        int         mode;    // 0 plain, 2 forced-period check, 3 spacing check
        int         exp_cc;  // -1: no end-of-phase count check
    } vec_t;

    initial begin
        vec_t vecs[5];
        bit   st, sp;
        int   nstep, last_sp, saved_cc, first_sp, bad_b_spawn, bad_b_lfsr;
        bit   seen;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.enable = 1'b0; bus_a.density = 4'd0;
        bus_b.enable = 1'b0; bus_b.density = 4'd0;

        vecs[0] = '{rst: 1, en: 0, den: 4'd0,  cycles: 3,   mode: 0, exp_cc: 0};
        vecs[1] = '{rst: 0, en: 1, den: 4'd0,  cycles: 60,  mode: 2, exp_cc: 3};
        vecs[2] = '{rst: 0, en: 1, den: 4'd0,  cycles: 2,   mode: 0, exp_cc: 3};
        vecs[3] = '{rst: 1, en: 1, den: 4'd9,  cycles: 1,   mode: 0, exp_cc: 0};
        vecs[4] = '{rst: 0, en: 1, den: 4'd15, cycles: 800, mode: 3, exp_cc: -1};

        for (int v = 0; v < 5; v++) begin
            nstep = 0; last_sp = -100;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick_a(vecs[v].rst, vecs[v].en, vecs[v].den, st, sp);
                if (st) nstep++;
                if (sp && vecs[v].mode == 2) check("forced_period", nstep % 5, 0);
                if (sp && vecs[v].mode == 3) begin
                    check("min_spacing", int'(nstep - last_sp >= MG + 1), 1);
                    last_sp = nstep;
                end
            end
            if (vecs[v].mode == 2) check("step_count_60clk", nstep, 15);
            if (vecs[v].exp_cc >= 0) check("phase_cc", int'(bus_a.car_count), vecs[v].exp_cc);
            if (v == 3) begin
                check("rst_step",  int'(bus_a.step),  0);
                check("rst_spawn", int'(bus_a.spawn), 0);
                check("rst_lfsr",  int'(u_a.u_lfsr.q), 1);
            end
        end

        // Drop enable right after a spawn, then re-enable.
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick_a(0, 1, 4'd15, st, sp);
            seen = sp;
        end
        check("spawn_before_drop", int'(seen), 1);
        saved_cc = int'(bus_a.car_count);
        for (int c = 0; c < 10; c++) begin
            tick_a(0, 0, 4'd15, st, sp);
            check("low_step",  int'(st), 0);
            check("low_spawn", int'(sp), 0);
        end
        check("cc_kept_low", int'(bus_a.car_count), saved_cc);
        nstep = 0; first_sp = -1;
        for (int c = 0; c < 100 && first_sp < 0; c++) begin
            tick_a(0, 1, 4'd15, st, sp);
            if (st) nstep++;
            if (sp) first_sp = nstep;
        end
        check("reenable_gap", int'(first_sp >= MG + 1), 1);

        // Saturation of car_count with forced spawns only.
        for (int c = 0; c < 5400; c++) tick_a(0, 1, 4'd0, st, sp);
        check("cc_saturated", int'(bus_a.car_count), 255);
        for (int c = 0; c < 60; c++) tick_a(0, 1, 4'd0, st, sp);
        check("cc_holds", int'(bus_a.car_count), 255);

        // Instance B: zero seed, forcing disabled, density 0.
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("b_reset_lfsr", int'(u_b.u_lfsr.q), 1);
        check("b_reset_cc",   int'(bus_b.car_count), 0);
        rst_b = 1'b0;
        bus_b.enable = 1'b1;
        bad_b_spawn = 0; bad_b_lfsr = 0; nstep = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (bus_b.step) nstep++;
            if (bus_b.spawn) bad_b_spawn++;
            if (u_b.u_lfsr.q == 10'h000) bad_b_lfsr++;
        end
        check("b_steps",       nstep, 1000);
        check("b_no_spawn",    bad_b_spawn, 0);
        check("b_lfsr_nonzero", bad_b_lfsr, 0);
        check("b_cc_zero",     int'(bus_b.car_count), 0);
        check("b_lfsr_moved",  int'(u_b.u_lfsr.q != 10'h001), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
